// File: rtl/s16_stream_checker.sv
// Reassembles two-beat half-word runs into 32-bit words and checks them against an incrementing pattern.
// Outputs are registered and appear one cycle after the closing low sample; there is no backpressure.
module s16_stream_checker #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      s16,
  input  logic             n16rdy,
  input  logic             clr,
  output logic [31:0]      word,
  output logic             word_vld,
  output logic             locked,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] frm_cnt,
  output logic             err_flag,
  output logic [31:0]      first_got,
  output logic [31:0]      first_exp
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2,
    OVER = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t      state;
  logic [15:0] hi_q;
  logic [15:0] lo_q;
  logic [31:0] exp_q;
  logic [31:0] asm_word;
  logic        commit;
  logic        frm_evt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // A word closes only when the low sample follows exactly two high samples.
  always_comb begin
    asm_word = {hi_q, lo_q};
    commit   = (state == LO) && !n16rdy;
    frm_evt  = ((state == HI) || (state == OVER)) && !n16rdy;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      exp_q     <= '0;
      word      <= '0;
      word_vld  <= 1'b0;
      locked    <= 1'b0;
      word_cnt  <= '0;
      err_cnt   <= '0;
      frm_cnt   <= '0;
      err_flag  <= 1'b0;
      first_got <= '0;
      first_exp <= '0;
    end else begin
      word_vld <= 1'b0;

      // Framing keeps running through clr so an in-flight word is not lost.
      case (state)
        IDLE: begin
          if (n16rdy) begin
            hi_q  <= s16;
            state <= HI;
          end
        end
        HI: begin
          if (n16rdy) begin
            lo_q  <= s16;
            state <= LO;
          end else begin
            state <= IDLE;
          end
        end
        LO:      state <= n16rdy ? OVER : IDLE;
        OVER:    if (!n16rdy) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (clr) begin
        exp_q     <= '0;
        locked    <= 1'b0;
        word_cnt  <= '0;
        err_cnt   <= '0;
        frm_cnt   <= '0;
        err_flag  <= 1'b0;
        first_got <= '0;
        first_exp <= '0;
      end else begin
        if (commit) begin
          word     <= asm_word;
          word_vld <= 1'b1;
          word_cnt <= sat_inc(word_cnt);
          if (!locked) begin
            exp_q  <= asm_word + 32'd1;
            locked <= 1'b1;
          end else begin
            if (asm_word != exp_q) begin
              err_cnt <= sat_inc(err_cnt);
              if (!err_flag) begin
                err_flag  <= 1'b1;
                first_got <= asm_word;
                first_exp <= exp_q;
              end
            end
            // Pattern free-runs; a bad word never re-syncs it.
            exp_q <= exp_q + 32'd1;
          end
        end
        if (frm_evt) begin
          frm_cnt <= sat_inc(frm_cnt);
        end
      end
    end
  end

endmodule

// File: tb/tb_s16_stream_checker.sv
// Randomized and directed bench for s16_stream_checker, with a run-level reference model.
module tb_s16_stream_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] s16;
  logic        n16rdy;
  logic        clr;

  logic [31:0] word, first_got, first_exp, word_cnt, err_cnt, frm_cnt;
  logic        word_vld, locked, err_flag;
  logic [31:0] word4, first_got4, first_exp4;
  logic [3:0]  word_cnt4, err_cnt4, frm_cnt4;
  logic        word_vld4, locked4, err_flag4;

  int errors = 0;
  int checks = 0;

  s16_stream_checker u_dut (
    .clk(clk), .rst_n(rst_n), .s16(s16), .n16rdy(n16rdy), .clr(clr),
    .word(word), .word_vld(word_vld), .locked(locked),
    .word_cnt(word_cnt), .err_cnt(err_cnt), .frm_cnt(frm_cnt),
    .err_flag(err_flag), .first_got(first_got), .first_exp(first_exp)
  );

  s16_stream_checker #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .s16(s16), .n16rdy(n16rdy), .clr(clr),
    .word(word4), .word_vld(word_vld4), .locked(locked4),
    .word_cnt(word_cnt4), .err_cnt(err_cnt4), .frm_cnt(frm_cnt4),
    .err_flag(err_flag4), .first_got(first_got4), .first_exp(first_exp4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // Reference model: state per run, index 0 = 32-bit counters, 1 = 4-bit counters.
  logic [31:0] m_wcnt[2], m_ecnt[2], m_fcnt[2];
  logic [31:0] m_max[2] = '{32'hFFFF_FFFF, 32'h0000_000F};
  logic        m_locked, m_flag;
  logic [31:0] m_exp, m_fgot, m_fexp, m_word;
  logic [31:0] word_q[$];
  int          m_vld_exp = 0;
  int          vld_seen = 0;

  function automatic logic [31:0] sat(input logic [31:0] v, input logic [31:0] mx);
    return (v == mx) ? v : v + 32'd1;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 2; i++) begin
      m_wcnt[i] = 0; m_ecnt[i] = 0; m_fcnt[i] = 0;
    end
    m_locked = 0; m_flag = 0; m_fgot = 0; m_fexp = 0;
  endtask

  task automatic m_reset();
    m_clear();
    m_word = 0; m_exp = 0;
  endtask

  task automatic m_commit(input logic [31:0] w);
    for (int i = 0; i < 2; i++) m_wcnt[i] = sat(m_wcnt[i], m_max[i]);
    if (!m_locked) begin
      m_exp = w + 32'd1;
      m_locked = 1;
    end else begin
      if (w != m_exp) begin
        for (int i = 0; i < 2; i++) m_ecnt[i] = sat(m_ecnt[i], m_max[i]);
        if (!m_flag) begin
          m_flag = 1; m_fgot = w; m_fexp = m_exp;
        end
      end
      m_exp = m_exp + 32'd1;
    end
    m_word = w;
    word_q.push_back(w);
    m_vld_exp++;
  endtask

  task automatic m_frame();
    for (int i = 0; i < 2; i++) m_fcnt[i] = sat(m_fcnt[i], m_max[i]);
  endtask

  // Every pulse must carry the next expected word.
  always @(negedge clk) begin
    if (word_vld) begin
      vld_seen++;
      if (word_q.size() == 0) chk("vld_spurious", 32'd1, 32'd0);
      else chk("word_stream", word, word_q.pop_front());
    end
  end

  // clr_mode: 0 none, 1 clr on the closing low sample, 2 clr on the high-half sample.
  task automatic send_run(input int len, input logic [31:0] w, input int clr_mode);
    for (int k = 0; k < len; k++) begin
      @(posedge clk); #1;
      n16rdy = 1'b1;
      s16 = (k == 0) ? w[31:16] : (k == 1) ? w[15:0] : 16'($urandom);
      clr = (clr_mode == 2) && (k == 0);
    end
    @(posedge clk); #1;
    n16rdy = 1'b0;
    s16 = 16'($urandom);
    clr = (clr_mode == 1);
    if (clr_mode == 2) m_clear();
    if (clr_mode == 1) m_clear();
    else if (len == 2) m_commit(w);
    else m_frame();
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1;
    n16rdy = 1'b0;
    clr = 1'b1;
    m_clear();
  endtask

  task automatic check_now(input string tag);
    chk({tag, ":word"}, word, m_word);
    chk({tag, ":word_cnt"}, word_cnt, m_wcnt[0]);
    chk({tag, ":err_cnt"}, err_cnt, m_ecnt[0]);
    chk({tag, ":frm_cnt"}, frm_cnt, m_fcnt[0]);
    chk({tag, ":locked"}, 32'(locked), 32'(m_locked));
    chk({tag, ":err_flag"}, 32'(err_flag), 32'(m_flag));
    chk({tag, ":first_got"}, first_got, m_fgot);
    chk({tag, ":first_exp"}, first_exp, m_fexp);
    chk({tag, ":word_cnt4"}, 32'(word_cnt4), m_wcnt[1]);
    chk({tag, ":err_cnt4"}, 32'(err_cnt4), m_ecnt[1]);
    chk({tag, ":frm_cnt4"}, 32'(frm_cnt4), m_fcnt[1]);
    chk({tag, ":vld_count"}, 32'(vld_seen), 32'(m_vld_exp));
  endtask

  task automatic settle(input string tag);
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk); #1;
    check_now(tag);
  endtask

  initial begin
    logic [31:0] w;
    int len, mode;

    rst_n = 1'b0; n16rdy = 1'b0; s16 = '0; clr = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    check_now("reset");
    chk("reset:word_vld", 32'(word_vld), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) send_run(2, 32'h10 + i, 0);
    settle("incr");

    pulse_clr();
    send_run(2, 32'hFFFF_FFFE, 0);
    send_run(2, 32'hFFFF_FFFF, 0);
    send_run(2, 32'h0000_0000, 0);
    settle("wrap");

    pulse_clr();
    send_run(2, 32'h100, 0);
    send_run(2, 32'h101, 0);
    send_run(2, 32'h1AA, 0);
    settle("err1");
    send_run(2, 32'h103, 0);
    send_run(2, 32'h1BB, 0);
    settle("err2");

    pulse_clr();
    send_run(1, 32'h1111_2222, 0);
    send_run(3, 32'h3333_4444, 0);
    send_run(5, 32'h5555_6666, 0);
    send_run(2, 32'h777, 0);
    settle("framing");

    pulse_clr();
    send_run(2, 32'h50, 0);
    for (int i = 0; i < 20; i++) send_run(2, 32'hDEAD_0000 + i, 0);
    settle("saturate");

    // Reset lands between the high and low halves.
    @(posedge clk); #1;
    n16rdy = 1'b1; s16 = 16'h1234;
    @(posedge clk); #1;
    n16rdy = 1'b0; s16 = 16'h5678; rst_n = 1'b0;
    m_reset();
    @(negedge clk); #1;
    check_now("midword_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_run(2, 32'hABCD_0001, 0);
    settle("post_rst");

    send_run(2, 32'h20, 0);
    settle("pre_clr");
    send_run(2, 32'h21, 1);
    settle("clr_commit");
    send_run(2, 32'h30, 0);
    settle("reseed");
    send_run(2, 32'h40, 2);
    settle("clr_inflight");

    for (int i = 0; i < 40; i++) send_run(2, 32'h9000 + i, 0);
    settle("throughput");

    for (int i = 0; i < 250; i++) begin
      case ($urandom % 8)
        0: len = 1;
        1: len = 3;
        2: len = 2 + ($urandom % 4);
        default: len = 2;
      endcase
      w = (m_locked && ($urandom % 4 != 0)) ? m_exp : $urandom;
      mode = ($urandom % 16 == 0) ? 1 + ($urandom % 2) : 0;
      send_run(len, w, mode);
      if ($urandom % 8 == 0) settle("random");
    end
    settle("random_end");
    chk("queue_empty", 32'(word_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/s16_stream_checker.md
# s16_stream_checker

Checks the 16-bit half-word stream produced by the 32→16 adapter of the SDRAM stream test path. Each word arrives as exactly two consecutive `n16rdy` cycles, high half first, then low half. The block reassembles the words and checks them against an incrementing 32-bit counter pattern. It counts words, data errors and framing errors, and captures the first mismatch for readout.

## Interface
- `CNT_W`, default 32: width of the word, error and framing counters; all counters saturate.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `s16` in 16: half-word data, valid when `n16rdy`=1.
- `n16rdy` in 1: half-word valid.
- `clr` in 1: synchronous clear of counters, lock and capture; takes priority over updates in the same cycle.
- `word` out 32: last reassembled word, `{high, low}`.
- `word_vld` out 1: one-cycle pulse when `word` is updated.
- `locked` out 1: expected pattern has been seeded.
- `word_cnt` out CNT_W: number of words committed.
- `err_cnt` out CNT_W: number of data mismatches.
- `frm_cnt` out CNT_W: number of framing errors.
- `err_flag` out 1: sticky; set on the first mismatch.
- `first_got` out 32: received word at the first mismatch.
- `first_exp` out 32: expected word at the first mismatch.

## Operation
- FSM states and transitions, all evaluated on the sampled `n16rdy`:
  - IDLE, `n16rdy`=1: latch `s16` as the high half; go to HI.
  - HI, `n16rdy`=1: latch `s16` as the low half; go to LO.
  - HI, `n16rdy`=0: run of length 1; framing error; go to IDLE.
  - LO, `n16rdy`=0: commit the word; go to IDLE.
  - LO, `n16rdy`=1: run longer than 2; go to OVER. No commit.
  - OVER, `n16rdy`=1: stay in OVER.
  - OVER, `n16rdy`=0: framing error, counted once per run; go to IDLE.
- Commit sequence:
  - Set `word` = `{hi, lo}` and pulse `word_vld`.
  - Increment `word_cnt`.
  - If `locked`=0: set `exp` ← word+1 and `locked` ← 1. No compare is made.
  - Else if word ≠ `exp`: increment `err_cnt`. If `err_flag`=0, capture `first_got`/`first_exp` and set `err_flag`.
  - In both locked cases, `exp` ← `exp`+1, mod 2^32. There is no re-sync to received data.
- Arithmetic:
  - Expected pattern wraps FFFFFFFF→00000000 without error.
  - Counters saturate at all-ones and do not wrap.
- `clr`:
  - Zeroes all counters, `locked`, `err_flag`, `first_got` and `first_exp`.
  - A commit or framing error in the same cycle is discarded, not counted.
  - The FSM keeps running, so an in-flight word is still framed correctly.
  - The next committed word re-seeds the pattern.
- Reset (`rst_n`=0), at any time including mid-word:
  - FSM goes to IDLE; any partial word is discarded.
  - All outputs and `exp` go to 0: `word`, `word_vld`, `locked`, all counters, `err_flag`, `first_*`.

## Timing
- Fully registered outputs; no combinational path from inputs to outputs.
- Commit latency:
  - High half is sampled at edge e0 and low half at e1.
  - `n16rdy`=0 is sampled at e2.
  - After e2, `word_vld`=1 for one cycle, and `word` and the counters are updated. `word_vld` returns to 0 after e3.
- Framing errors:
  - A run of length 1 sampled at e0 with `n16rdy`=0 at e1: `frm_cnt` increments after e1.
  - A run longer than 2: `frm_cnt` increments after the first low sample.
- Minimum legal spacing is one idle cycle between runs, giving one word every 3 cycles. This must be sustained indefinitely with no loss.
- `n16rdy` must be low for at least one cycle after a run; a 2-cycle run immediately followed by another run is a single over-length run.
- `err_flag`, `first_got` and `first_exp` update in the same cycle as the `err_cnt` increment.

## Test plan
- Words 0x00000010..0x00000013 sent as 2-cycle runs with 1 idle cycle between → `word_vld` ×4, `locked`=1 after the first word, `word_cnt`=4, `err_cnt`=0, `frm_cnt`=0.
- Seed with 0xFFFFFFFE, then send 0xFFFFFFFF and 0x00000000 → wrap accepted, `err_cnt`=0, `word_cnt`=3.
- Seed 0x100, then send 0x101, 0x1AA, 0x103, 0x1BB → `err_cnt`=2, `first_got`=0x1AA, `first_exp`=0x102, `err_flag`=1, capture unchanged by the second error.
- `n16rdy` runs of length 1, then 3, then 5, then a legal word → `frm_cnt`=3, `word_cnt`=1, with the legal word seeding lock.
- Set `CNT_W`=4, send 20 mismatching words after the seed → `err_cnt` holds at 0xF and `word_cnt` holds at 0xF.
- Assert `rst_n` low between the high and low half, release, then send a legal word; separately, pulse `clr` in the commit cycle → all outputs are 0 after reset and the post-reset word seeds `locked`. The `clr`-cycle word is not counted, and `locked`=0 until the next word.
